// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor.
// The WIDTH-bit operands are split into CHUNK-bit slices, and each pipeline stage ripples one
// slice. The carry is registered between stages. Unprocessed upper slices travel forward through
// skew registers, and finished lower sum slices travel forward through deskew registers, so every
// slice of a transaction leaves the last stage in the same cycle.
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  if (CHUNK == 0 || WIDTH % CHUNK != 0 || STAGES < 1) begin : gen_param_check
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Pipeline registers, one entry per stage.
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q   [STAGES];  // operand A skew
  logic [WIDTH-1:0]  bc_q  [STAGES];  // operand B (conditionally inverted) skew
  logic [WIDTH-1:0]  sum_q [STAGES];  // completed lower slices (deskew)
  logic [STAGES-1:0] cry_q;           // carry out of the slice handled by each stage
  logic              ovf_q;
  logic              zero_q;

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0]  a_in    [STAGES];
  logic [WIDTH-1:0]  bc_in   [STAGES];
  logic [WIDTH-1:0]  sum_in  [STAGES];
  logic [WIDTH-1:0]  sum_nxt [STAGES];
  logic [STAGES-1:0] cin;
  logic [STAGES-1:0] cry_nxt;
  logic [CHUNK:0]    slice;
  logic              msb_cin;
  logic              ovf_d;
  logic              zero_d;

  // The whole pipe either moves together or holds together; there is no bubble collapsing.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage operand selection: stage 0 reads the ports, later stages read their predecessor.
  always_comb begin
    cin       = '0;
    a_in[0]   = A;
    bc_in[0]  = B ^ {WIDTH{sub}};
    sum_in[0] = '0;
    cin[0]    = sub;  // +1 completes the two's-complement negate of B
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      bc_in[k]  = bc_q[k-1];
      sum_in[k] = sum_q[k-1];
      cin[k]    = cry_q[k-1];
    end
  end

  // Each stage ripples exactly one CHUNK-bit slice and merges it into the partial sum.
  always_comb begin
    slice   = '0;
    cry_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
            + {1'b0, bc_in[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, cin[k]};
      sum_nxt[k]                   = sum_in[k];
      sum_nxt[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      cry_nxt[k]                   = slice[CHUNK];
    end
  end

  // Flags derived in the last stage. Carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    msb_cin = a_in[LAST][WIDTH-1] ^ bc_in[LAST][WIDTH-1] ^ sum_nxt[LAST][WIDTH-1];
    ovf_d   = msb_cin ^ cry_nxt[LAST];
    zero_d  = ~|sum_nxt[LAST];
  end

  // Pipeline state: valid bits travel with the data, and everything shifts when adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bc_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_in[k];
        bc_q[k]  <= bc_in[k];
        sum_q[k] <= sum_nxt[k];
        cry_q[k] <= cry_nxt[k];
      end
    end
  end

  // Output flag registers, loaded in step with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign Sum       = sum_q[LAST];
  assign Cout      = cry_q[LAST];
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed cases on an 8/4 instance, plus random sweeps on four
// WIDTH/CHUNK configurations checked against a signed/unsigned arithmetic reference model.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sub;
  logic [31:0] a_bus;
  logic [31:0] b_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int wid [4];

  always #5 clk = ~clk;

  // Per-instance outputs.
  logic        rdy0, ov0, co0, of0, zr0;
  logic [7:0]  sum0;
  logic        rdy1, ov1, co1, of1, zr1;
  logic [15:0] sum1;
  logic        rdy2, ov2, co2, of2, zr2;
  logic [7:0]  sum2;
  logic        rdy3, ov3, co3, of3, zr3;
  logic [31:0] sum3;

  logic        rdy_a [4];
  logic        ov_a  [4];
  logic [34:0] res_a [4];  // {sum, cout, ovf, zero}

  assign rdy_a[0] = rdy0;
  assign rdy_a[1] = rdy1;
  assign rdy_a[2] = rdy2;
  assign rdy_a[3] = rdy3;
  assign ov_a[0]  = ov0;
  assign ov_a[1]  = ov1;
  assign ov_a[2]  = ov2;
  assign ov_a[3]  = ov3;
  assign res_a[0] = {24'd0, sum0, co0, of0, zr0};
  assign res_a[1] = {16'd0, sum1, co1, of1, zr1};
  assign res_a[2] = {24'd0, sum2, co2, of2, zr2};
  assign res_a[3] = {sum3, co3, of3, zr3};

  pipelined_add_sub #(.WIDTH(8), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .A(a_bus[7:0]), .B(b_bus[7:0]), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
    .Sum(sum0), .Cout(co0), .Ovf(of0), .Zero(zr0)
  );
  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .A(a_bus[15:0]), .B(b_bus[15:0]), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .Sum(sum1), .Cout(co1), .Ovf(of1), .Zero(zr1)
  );
  pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .A(a_bus[7:0]), .B(b_bus[7:0]), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
    .Sum(sum2), .Cout(co2), .Ovf(of2), .Zero(zr2)
  );
  pipelined_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .A(a_bus), .B(b_bus), .sub(sub), .out_valid(ov3), .out_ready(out_ready),
    .Sum(sum3), .Cout(co3), .Ovf(of3), .Zero(zr3)
  );

  // Reference: unsigned result/carry and signed overflow from plain integer arithmetic.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
    exp_t   e;
    longint m;
    longint half;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint r;
    longint sr;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!s) begin
      r      = ua + ub;
      e.cout = (r >= m);
      sr     = sa + sb;
    end else begin
      r      = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end
    if (r < 0) r = r + m;
    if (r >= m) r = r - m;
    e.sum  = r[31:0];
    e.ovf  = (sr >= half) || (sr < -half);
    e.zero = (r == 0);
    return e;
  endfunction

  // Present one transaction for one cycle; returns #1 after the following negedge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    in_valid = 1'b1;
    a_bus    = {24'd0, a};
    b_bus    = {24'd0, b};
    sub      = s;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sub       = 1'b0;
    a_bus     = '0;
    b_bus     = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    n_tests++; if (sum0 !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum0); end
    n_tests++; if ({co0, of0, zr0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {co0, of0, zr0});
    end
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", rdy0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", rdy0); end
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", ov0); end
  endtask

  task automatic test_add();
    issue(8'h5A, 8'h3C, 1'b0);
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b want 0", ov0); end
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", ov0); end
    n_tests++; if (sum0 !== 8'h96) begin n_fail++; $display("FAIL add_sum: got %h want 96", sum0); end
    n_tests++; if ({co0, of0, zr0} !== 3'b010) begin
      n_fail++; $display("FAIL add_flags: got cout/ovf/zero %b want 010", {co0, of0, zr0});
    end
  endtask

  task automatic test_sub();
    issue(8'h10, 8'h20, 1'b1);
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1 || sum0 !== 8'hF0) begin
      n_fail++; $display("FAIL sub_borrow_sum: got v=%b %h want v=1 F0", ov0, sum0);
    end
    n_tests++; if ({co0, of0, zr0} !== 3'b000) begin
      n_fail++; $display("FAIL sub_borrow_flags: got %b want 000", {co0, of0, zr0});
    end
    issue(8'h80, 8'h01, 1'b1);
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1 || sum0 !== 8'h7F) begin
      n_fail++; $display("FAIL sub_ovf_sum: got v=%b %h want v=1 7F", ov0, sum0);
    end
    n_tests++; if ({co0, of0, zr0} !== 3'b110) begin
      n_fail++; $display("FAIL sub_ovf_flags: got %b want 110", {co0, of0, zr0});
    end
  endtask

  task automatic test_carry();
    issue(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1 || sum0 !== 8'h00) begin
      n_fail++; $display("FAIL wrap_sum: got v=%b %h want v=1 00", ov0, sum0);
    end
    n_tests++; if ({co0, of0, zr0} !== 3'b101) begin
      n_fail++; $display("FAIL wrap_flags: got %b want 101", {co0, of0, zr0});
    end
    issue(8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1 || sum0 !== 8'h10) begin
      n_fail++; $display("FAIL slice_carry_sum: got v=%b %h want v=1 10", ov0, sum0);
    end
    n_tests++; if ({co0, of0, zr0} !== 3'b000) begin
      n_fail++; $display("FAIL slice_carry_flags: got %b want 000", {co0, of0, zr0});
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int   sent;
    int   got;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 6);
      a_bus     = $urandom;
      b_bus     = $urandom;
      sub       = ($urandom_range(0, 1) != 0);
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (ov0) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got %h with nothing outstanding", sum0);
        end else begin
          e = q[0];
          if ({sum0, co0, of0, zr0} !== {e.sum[7:0], e.cout, e.ovf, e.zero}) begin
            n_fail++;
            $display("FAIL stream_result: got %h/%b want %h/%b", sum0, {co0, of0, zr0},
                     e.sum[7:0], {e.cout, e.ovf, e.zero});
          end
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
        if (!out_ready) begin
          n_tests++;
          if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", rdy0); end
        end
      end
      if (in_valid && rdy0) begin
        q.push_back(model(8, a_bus, b_bus, sub));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (got != 6 || q.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d results (%0d pending) want 6 (0)", got, q.size());
    end
  endtask

  task automatic test_reset_mid_flight();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    a_bus    = 32'h11;
    b_bus    = 32'h22;
    sub      = 1'b0;
    @(negedge clk);
    a_bus    = 32'h33;
    b_bus    = 32'h44;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ov0); end
    n_tests++; if ({sum0, co0, of0, zr0} !== 11'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h/%b want 00/000", sum0, {co0, of0, zr0});
    end
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", rdy0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_tests++; if (ov0 !== 1'b0) begin
        n_fail++; $display("FAIL midrst_stale: got valid %b sum %h want no result", ov0, sum0);
      end
    end
    issue(8'h01, 8'h01, 1'b0);
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL cold_early_valid: got %b want 0", ov0); end
    @(negedge clk);
    #1;
    n_tests++; if (ov0 !== 1'b1 || sum0 !== 8'h02) begin
      n_fail++; $display("FAIL cold_sum: got v=%b %h want v=1 02", ov0, sum0);
    end
  endtask

  task automatic test_param_sweep();
    exp_t sb_mem [4][16];
    exp_t e;
    int   wr_p [4];
    int   rd_p [4];
    int   acc_n [4];
    int   cyc;
    bit   all_in;
    bit   drained;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_p[i]  = 0;
      rd_p[i]  = 0;
      acc_n[i] = 0;
    end
    cyc = 0;
    while (cyc < 20000) begin
      all_in  = 1'b1;
      drained = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (acc_n[i] < 1000) all_in = 1'b0;
        if (wr_p[i] != rd_p[i]) drained = 1'b0;
      end
      if (all_in && drained) break;
      @(negedge clk);
      in_valid  = !all_in && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_bus     = $urandom;
      b_bus     = $urandom;
      sub       = ($urandom_range(0, 1) != 0);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ov_a[i]) begin
          n_tests++;
          if (wr_p[i] == rd_p[i]) begin
            n_fail++; $display("FAIL sweep%0d_extra: got %h with nothing outstanding", i, res_a[i]);
          end else begin
            e = sb_mem[i][rd_p[i] % 16];
            if (res_a[i] !== {e.sum, e.cout, e.ovf, e.zero}) begin
              n_fail++;
              $display("FAIL sweep%0d_result: got %h want %h", i, res_a[i],
                       {e.sum, e.cout, e.ovf, e.zero});
            end
            if (out_ready) rd_p[i]++;
          end
        end
        n_tests++;
        if (rdy_a[i] !== (!ov_a[i] || out_ready)) begin
          n_fail++; $display("FAIL sweep%0d_in_ready: got %b want %b", i, rdy_a[i],
                             !ov_a[i] || out_ready);
        end
        if (in_valid && rdy_a[i]) begin
          sb_mem[i][wr_p[i] % 16] = model(wid[i], a_bus, b_bus, sub);
          wr_p[i]++;
          acc_n[i]++;
        end
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (cyc >= 20000) begin
      n_fail++; $display("FAIL sweep_timeout: got %0d cycles want fewer than 20000", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (acc_n[i] < 1000 || wr_p[i] != rd_p[i]) begin
        n_fail++; $display("FAIL sweep%0d_count: got %0d accepted %0d drained want >=1000 all",
                           i, acc_n[i], rd_p[i]);
      end
    end
  endtask

  initial begin
    wid[0] = 8;
    wid[1] = 16;
    wid[2] = 8;
    wid[3] = 32;
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_back_to_back();
    test_reset_mid_flight();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
